// File: rtl/key_event_fsm_if.sv
// rtl/key_event_fsm_if.sv - byte-in / event-out bundle between the PS/2 receiver, key_event_fsm and the snake controller
//
// Signals:
//   strobe              byte-ready level; each 0->1 transition delivers one byte
//   key_code1/key_code0 high/low nibble of the scan-code byte
//   start/resume/stop/pause  one-cycle command pulses
//   up/down/left/right  one-hot current direction levels
//   mode                00 STOPPED, 01 RUNNING, 10 PAUSED
// Modports:
//   master  byte source / event sink (receiver side plus controller side)
//   slave   key_event_fsm
interface key_event_fsm_if;
    logic       strobe;
    logic [3:0] key_code1;
    logic [3:0] key_code0;
    logic       start;
    logic       resume;
    logic       stop;
    logic       pause;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [1:0] mode;

    modport master (
        output strobe, key_code1, key_code0,
        input  start, resume, stop, pause, up, down, left, right, mode
    );

    modport slave (
        input  strobe, key_code1, key_code0,
        output start, resume, stop, pause, up, down, left, right, mode
    );
endinterface

// File: rtl/key_event_fsm.sv
// rtl/key_event_fsm.sv - PS/2 scan-code parser turning key presses into snake game commands and direction
//
// Ports:
//   clk100Mhz  system clock, all state updates on its rising edge
//   reset      synchronous active-high reset
//   bus        key_event_fsm_if.slave (strobe/key codes in; pulses, direction, mode out)
// Parameter:
//   PREFIX_TIMEOUT  cycles a prefix state (E0, F0, E0F0) waits for its next byte
// Configuration macro:
//   KEY_EVENT_NO_REVERSE_EN  when defined, a direction key opposite the current
//                            direction is ignored; when undefined, reversals are accepted
module key_event_fsm #(
    parameter int PREFIX_TIMEOUT = 2000000
) (
    input  logic           clk100Mhz,
    input  logic           reset,
    key_event_fsm_if.slave bus
);

    typedef enum logic [1:0] {
        P_IDLE = 2'b00,
        P_E0   = 2'b01,
        P_F0   = 2'b10,
        P_E0F0 = 2'b11
    } parse_t;

    typedef enum logic [1:0] {
        M_STOPPED = 2'b00,
        M_RUNNING = 2'b01,
        M_PAUSED  = 2'b10
    } mode_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_START,
        C_RESUME,
        C_PAUSE,
        C_STOP
    } cmd_t;

    localparam int TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(PREFIX_TIMEOUT - 1);

    // Direction vectors are ordered {up, down, left, right}.
    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;

    parse_t        parse_q;
    mode_t         mode_q;
    logic [3:0]    dir_q;
    logic [TW-1:0] timer_q;
    logic          strobe_q;
    logic          blocked_q;
    logic          start_q;
    logic          resume_q;
    logic          stop_q;
    logic          pause_q;

    logic [7:0]    byte_in;
    logic          byte_edge;
    cmd_t          cmd;
    logic [3:0]    dir_req;
    logic [3:0]    dir_opp;
    logic          dir_ok;

    assign byte_in = {bus.key_code1, bus.key_code0};

    // blocked_q masks a strobe that was already high when reset released, so
    // that level is not mistaken for a fresh byte.
    assign byte_edge = bus.strobe & ~strobe_q & ~blocked_q;

    // Decode the byte of this edge into at most one event.
    always_comb begin
        cmd     = C_NONE;
        dir_req = 4'b0000;
        if (byte_edge) begin
            if (parse_q == P_IDLE) begin
                case (byte_in)
                    8'h1B:   cmd = C_START;
                    8'h2D:   cmd = C_RESUME;
                    8'h4D:   cmd = C_PAUSE;
                    8'h76:   cmd = C_STOP;
                    default: cmd = C_NONE;
                endcase
            end else if (parse_q == P_E0) begin
                case (byte_in)
                    8'h75:   dir_req = D_UP;
                    8'h72:   dir_req = D_DOWN;
                    8'h6B:   dir_req = D_LEFT;
                    8'h74:   dir_req = D_RIGHT;
                    default: dir_req = 4'b0000;
                endcase
            end
        end
    end

    // Opposite of the current direction: swap up/down and left/right.
    assign dir_opp = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};

`ifdef KEY_EVENT_NO_REVERSE_EN
    assign dir_ok = (mode_q == M_RUNNING) && (dir_req != 4'b0000) && (dir_req != dir_opp);
`else
    assign dir_ok = (mode_q == M_RUNNING) && (dir_req != 4'b0000) && (dir_opp == dir_opp);
`endif

    always_ff @(posedge clk100Mhz) begin
        if (reset) begin
            parse_q   <= P_IDLE;
            mode_q    <= M_STOPPED;
            dir_q     <= D_RIGHT;
            timer_q   <= '0;
            strobe_q  <= 1'b0;
            blocked_q <= bus.strobe;
            start_q   <= 1'b0;
            resume_q  <= 1'b0;
            stop_q    <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            strobe_q <= bus.strobe;
            if (!bus.strobe) begin
                blocked_q <= 1'b0;
            end

            start_q  <= 1'b0;
            resume_q <= 1'b0;
            stop_q   <= 1'b0;
            pause_q  <= 1'b0;

            // Parser: every byte restarts the prefix wait; a prefix state
            // with no byte for PREFIX_TIMEOUT cycles drops back to IDLE.
            if (byte_edge) begin
                timer_q <= '0;
                case (parse_q)
                    P_IDLE: begin
                        if (byte_in == 8'hE0) begin
                            parse_q <= P_E0;
                        end else if (byte_in == 8'hF0) begin
                            parse_q <= P_F0;
                        end else begin
                            parse_q <= P_IDLE;
                        end
                    end
                    P_E0: begin
                        if (byte_in == 8'hF0) begin
                            parse_q <= P_E0F0;
                        end else begin
                            parse_q <= P_IDLE;
                        end
                    end
                    default: parse_q <= P_IDLE;
                endcase
            end else if (parse_q != P_IDLE) begin
                if (timer_q == T_LAST) begin
                    parse_q <= P_IDLE;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end

            // Mode FSM: only legal transitions pulse and change state.
            case (cmd)
                C_START: begin
                    if (mode_q == M_STOPPED) begin
                        mode_q  <= M_RUNNING;
                        start_q <= 1'b1;
                        dir_q   <= D_RIGHT;
                    end
                end
                C_PAUSE: begin
                    if (mode_q == M_RUNNING) begin
                        mode_q  <= M_PAUSED;
                        pause_q <= 1'b1;
                    end
                end
                C_RESUME: begin
                    if (mode_q == M_PAUSED) begin
                        mode_q   <= M_RUNNING;
                        resume_q <= 1'b1;
                    end
                end
                C_STOP: begin
                    if (mode_q != M_STOPPED) begin
                        mode_q <= M_STOPPED;
                        stop_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (dir_ok) begin
                dir_q <= dir_req;
            end
        end
    end

    assign bus.start  = start_q;
    assign bus.resume = resume_q;
    assign bus.stop   = stop_q;
    assign bus.pause  = pause_q;
    assign bus.up     = dir_q[3];
    assign bus.down   = dir_q[2];
    assign bus.left   = dir_q[1];
    assign bus.right  = dir_q[0];
    assign bus.mode   = mode_q;

endmodule

// File: tb/tb_key_event_fsm.sv
// tb/tb_key_event_fsm.sv - directed table-driven bench for key_event_fsm
module tb_key_event_fsm;

    localparam int P = 16;

`ifdef KEY_EVENT_NO_REVERSE_EN
    localparam bit NOREV = 1'b1;
`else
    localparam bit NOREV = 1'b0;
`endif

    // {start,resume,stop,pause}
    localparam logic [3:0] PN  = 4'b0000;
    localparam logic [3:0] PST = 4'b1000;
    localparam logic [3:0] PRS = 4'b0100;
    localparam logic [3:0] PSP = 4'b0010;
    localparam logic [3:0] PPA = 4'b0001;
    // {up,down,left,right}
    localparam logic [3:0] DU = 4'b1000;
    localparam logic [3:0] DD = 4'b0100;
    localparam logic [3:0] DL = 4'b0010;
    localparam logic [3:0] DR = 4'b0001;
    // direction after E0 6B from right, and after E0 75 from down
    localparam logic [3:0] D6  = NOREV ? DR : DL;
    localparam logic [3:0] D24 = NOREV ? DD : DU;

    typedef struct {
        logic [7:0] b;
        logic [3:0] pulse;
        logic [1:0] mode;
        logic [3:0] dir;
    } vec_t;

    logic clk100Mhz = 1'b0;
    logic reset     = 1'b1;
    int   errors    = 0;
    int   checks    = 0;
    vec_t vecs[$];

    key_event_fsm_if bus ();

    key_event_fsm #(.PREFIX_TIMEOUT(P)) dut (
        .clk100Mhz (clk100Mhz),
        .reset     (reset),
        .bus       (bus.slave)
    );

    always #5 clk100Mhz = ~clk100Mhz;

    function automatic logic [3:0] pulses();
        return {bus.start, bus.resume, bus.stop, bus.pause};
    endfunction

    function automatic logic [3:0] dirs();
        return {bus.up, bus.down, bus.left, bus.right};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] p, input logic [1:0] m, input logic [3:0] d);
        check({name, " pulse"}, {4'b0, pulses()}, {4'b0, p});
        check({name, " mode"}, {6'b0, bus.mode}, {6'b0, m});
        check({name, " dir"}, {4'b0, dirs()}, {4'b0, d});
    endtask

    // One byte: strobe high for one cycle, check outputs after the detect
    // cycle, then check the pulse has dropped one cycle later.
    task automatic apply(input string name, input logic [7:0] b,
                         input logic [3:0] p, input logic [1:0] m, input logic [3:0] d);
        @(negedge clk100Mhz);
        bus.key_code1 = b[7:4];
        bus.key_code0 = b[3:0];
        bus.strobe    = 1'b1;
        @(negedge clk100Mhz);
        check_all(name, p, m, d);
        bus.strobe = 1'b0;
        @(negedge clk100Mhz);
        check({name, " width"}, {4'b0, pulses()}, 8'h00);
    endtask

    initial begin
        bus.strobe    = 1'b0;
        bus.key_code1 = 4'h0;
        bus.key_code0 = 4'h0;

        vecs.push_back('{8'h1B, PST, 2'b01, DR});
        vecs.push_back('{8'hE0, PN,  2'b01, DR});
        vecs.push_back('{8'h75, PN,  2'b01, DU});
        vecs.push_back('{8'hE0, PN,  2'b01, DU});
        vecs.push_back('{8'h74, PN,  2'b01, DR});
        vecs.push_back('{8'hE0, PN,  2'b01, DR});
        vecs.push_back('{8'h6B, PN,  2'b01, D6});
        vecs.push_back('{8'hF0, PN,  2'b01, D6});
        vecs.push_back('{8'h1B, PN,  2'b01, D6});
        vecs.push_back('{8'hE0, PN,  2'b01, D6});
        vecs.push_back('{8'hF0, PN,  2'b01, D6});
        vecs.push_back('{8'h75, PN,  2'b01, D6});
        vecs.push_back('{8'h1B, PN,  2'b01, D6});
        vecs.push_back('{8'h4D, PPA, 2'b10, D6});
        vecs.push_back('{8'hE0, PN,  2'b10, D6});
        vecs.push_back('{8'h72, PN,  2'b10, D6});
        vecs.push_back('{8'h4D, PN,  2'b10, D6});
        vecs.push_back('{8'h2D, PRS, 2'b01, D6});
        vecs.push_back('{8'h2D, PN,  2'b01, D6});
        vecs.push_back('{8'h75, PN,  2'b01, D6});
        vecs.push_back('{8'h6B, PN,  2'b01, D6});
        vecs.push_back('{8'hE0, PN,  2'b01, D6});
        vecs.push_back('{8'h1B, PN,  2'b01, D6});
        vecs.push_back('{8'hE0, PN,  2'b01, D6});
        vecs.push_back('{8'h72, PN,  2'b01, DD});
        vecs.push_back('{8'hE0, PN,  2'b01, DD});
        vecs.push_back('{8'h75, PN,  2'b01, D24});
        vecs.push_back('{8'h76, PSP, 2'b00, D24});
        vecs.push_back('{8'h76, PN,  2'b00, D24});
        vecs.push_back('{8'hE0, PN,  2'b00, D24});
        vecs.push_back('{8'h74, PN,  2'b00, D24});
        vecs.push_back('{8'h4D, PN,  2'b00, D24});
        vecs.push_back('{8'h2D, PN,  2'b00, D24});
        vecs.push_back('{8'h1B, PST, 2'b01, DR});
        vecs.push_back('{8'hE0, PN,  2'b01, DR});
        vecs.push_back('{8'h12, PN,  2'b01, DR});

        repeat (3) @(negedge clk100Mhz);
        check_all("reset", PN, 2'b00, DR);
        reset = 1'b0;
        @(negedge clk100Mhz);
        check_all("post_reset", PN, 2'b00, DR);

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d_%h", i, vecs[i].b), vecs[i].b, vecs[i].pulse, vecs[i].mode, vecs[i].dir);
        end

        // E0 abandoned after timeout: 75 is a plain make and ignored.
        apply("to_e0", 8'hE0, PN, 2'b01, DR);
        repeat (2 * P) @(negedge clk100Mhz);
        apply("to_75", 8'h75, PN, 2'b01, DR);
        // E0 with a short gap stays extended.
        apply("gap_e0", 8'hE0, PN, 2'b01, DR);
        repeat (P / 2) @(negedge clk100Mhz);
        apply("gap_75", 8'h75, PN, 2'b01, DU);

        // F0 abandoned after timeout: the next byte is a make again.
        apply("to_f0", 8'hF0, PN, 2'b01, DU);
        repeat (2 * P) @(negedge clk100Mhz);
        apply("to_4d", 8'h4D, PPA, 2'b10, DU);
        apply("to_2d", 8'h2D, PRS, 2'b01, DU);

        // Strobe held high: one event only, even if the code changes.
        @(negedge clk100Mhz);
        bus.key_code1 = 4'h4;
        bus.key_code0 = 4'hD;
        bus.strobe    = 1'b1;
        @(negedge clk100Mhz);
        check_all("hold_first", PPA, 2'b10, DU);
        bus.key_code1 = 4'h2;
        bus.key_code0 = 4'hD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk100Mhz);
            check_all($sformatf("hold_%0d", k), PN, 2'b10, DU);
        end
        bus.strobe = 1'b0;
        @(negedge clk100Mhz);

        // Reset coincident with an Esc edge while PAUSED.
        @(negedge clk100Mhz);
        bus.key_code1 = 4'h7;
        bus.key_code0 = 4'h6;
        bus.strobe    = 1'b1;
        reset         = 1'b1;
        @(negedge clk100Mhz);
        check_all("rst_esc", PN, 2'b00, DR);
        bus.key_code1 = 4'h1;
        bus.key_code0 = 4'hB;
        @(negedge clk100Mhz);
        reset = 1'b0;
        // Strobe still high after release must not start the game.
        repeat (3) @(negedge clk100Mhz);
        check_all("rst_held", PN, 2'b00, DR);
        bus.strobe = 1'b0;
        @(negedge clk100Mhz);
        apply("rst_start", 8'h1B, PST, 2'b01, DR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_fsm.md
KEY_EVENT_FSM -- requirements
Module: key_event_fsm

Interface
REQ-001 Parameter PREFIX_TIMEOUT, default 2000000; clk cycles a prefix state may wait for its next byte before it is abandoned.
REQ-002 clk100Mhz  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 strobe  input  1  byte-ready level from the PS/2 receiver; each 0->1 transition delivers one scan-code byte.
REQ-005 key_code1  input  4  high nibble of the received scan-code byte.
REQ-006 key_code0  input  4  low nibble of the received scan-code byte.
REQ-007 start, resume, stop, pause  output  1 each  one-cycle command pulses to the snake controller.
REQ-008 up, down, left, right  output  1 each  one-hot current-direction levels to the snake controller.
REQ-009 mode  output  2  game mode: 00 STOPPED, 01 RUNNING, 10 PAUSED.

Function
REQ-010 Rising-edge detect strobe against a registered copy; byte B = {key_code1,key_code0} sampled in the detect cycle.
REQ-011 Parser FSM states: IDLE, E0, F0, E0F0.
REQ-012 IDLE: B=E0 -> E0; B=F0 -> F0; any other B is a make code, decoded, stay IDLE.
REQ-013 E0: B=F0 -> E0F0; any other B decoded as extended make, -> IDLE.
REQ-014 F0 and E0F0: next byte is a break code, discarded, -> IDLE; break codes never generate events.
REQ-015 In E0, F0 or E0F0, PREFIX_TIMEOUT cycles without a byte -> IDLE, no event.
REQ-016 Non-extended makes: 1B (S) start, 2D (R) resume, 4D (P) pause, 76 (Esc) stop; all others ignored.
REQ-017 Extended makes: 75 up, 72 down, 6B left, 74 right; unlisted extended codes ignored.
REQ-018 Non-extended direction codes and extended command codes are ignored.
REQ-019 Mode FSM: start legal only in STOPPED -> RUNNING; pause only in RUNNING -> PAUSED; resume only in PAUSED -> RUNNING; stop legal in RUNNING or PAUSED -> STOPPED.
REQ-020 A command pulse is asserted only for a legal transition; illegal commands change nothing and emit no pulse.
REQ-021 Pulse and mode change appear the cycle after the strobe edge is detected; pulse width exactly one cycle.
REQ-022 Direction updates are accepted only in RUNNING; in STOPPED or PAUSED direction keys are ignored.
REQ-023 On start, direction is reloaded to right.
REQ-024 Direction outputs are always exactly one-hot; update latency equals command latency (REQ-021).
REQ-025 At most one event per strobe edge; strobe held high generates no further events.

Reset
REQ-026 While reset is high: parser IDLE, mode STOPPED, right=1, up=down=left=0, all pulses 0, timeout counter 0, strobe edge register 0.
REQ-027 Reset overrides a coincident strobe edge; that byte is lost.
REQ-028 A strobe that is already high when reset deasserts does not count as an edge.

Configuration
REQ-029 Macro KEY_EVENT_NO_REVERSE_EN defined: a direction key opposite the current direction (up/down, left/right) is ignored.
REQ-030 Macro undefined: any direction key in RUNNING is accepted, including reversals.

Verification
REQ-031 Reset, then bytes 1B, E0 75 -> start pulse 1 cycle, mode 01, then up=1 one cycle after the 75 edge.
REQ-032 RUNNING, direction right, bytes E0 6B -> with macro: right stays 1; without macro: left=1.
REQ-033 RUNNING, bytes F0 1B, then E0 F0 75 -> no pulses, mode and direction unchanged, parser IDLE.
REQ-034 Bytes 4D, 4D, 2D, 2D -> pause, (none), resume, (none); mode 01->10->01.
REQ-035 Byte E0, then 2,000,000 idle cycles, then 75 -> 75 treated as non-extended, direction unchanged.
REQ-036 Mode PAUSED, reset asserted in the cycle of an Esc strobe edge -> no stop pulse, mode 00, right=1.
